regfile_dump: RTL and testbench

//  Sequential reader for the 32x64 register file: on start, walks read addresses

---
 rtl/regfile_dump.sv | 154 +++++++++++++++
 tb/tb_regfile_dump.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//
// Purpose:
//   Sequential readout engine for the 32x64 register file. A start request
//   walks the read address from FIRST_REG up to LAST_REG inclusive through a
//   single regfile read port. Each word is captured and presented on a
//   valid/ready stream, tagged with the address it came from. This is the
//   debug/verification drain path that sits beside the datapath-written
//   regfile.
//
// Parameters:
//   DATA_W     width of a regfile word and of dout_data
//   ADDR_W     width of a regfile address
//   FIRST_REG  first address read
//   LAST_REG   last address read, inclusive (walk ends here, never wraps)
//
// Ports:
//   clk         in   1       clock, all state updates on the rising edge
//   reset_n     in   1       asynchronous active-low reset
//   start       in   1       begin a dump; only looked at while idle
//   busy        out  1       high while reading or holding a word
//   done        out  1       one-cycle pulse after the last word is accepted
//   ra          out  ADDR_W  regfile read address (the walk pointer)
//   rd          in   DATA_W  regfile read data, combinational in ra
//   dout_valid  out  1       dout_data/dout_addr hold a word
//   dout_ready  in   1       consumer takes the word when valid & ready
//   dout_data   out  DATA_W  captured register value
//   dout_addr   out  ADDR_W  address the word was read from
// ---------------------------------------------------------------------------
module regfile_dump #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_addr
);

    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State and output registers. Every output except ra comes straight
    // from a flop, so the consumer never sees combinational glitches and a
    // reset mid-dump drops the in-flight word immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= FIRST_PTR;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Everything holds by default, which is what keeps the
    // presented word stable while the consumer stalls in VALID. busy and done
    // are decoded from the next state so that, once registered, they line up
    // exactly with the state they describe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = FIRST_PTR;
                    state_d = READ;
                end
            end

            READ: begin
                data_d  = rd;
                addr_d  = ptr_q;
                valid_d = 1'b1;
                state_d = VALID;
            end

            VALID: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    // The walk stops at LAST_REG rather than wrapping, so a
                    // single-register window still terminates after one word.
                    if (ptr_q == LAST_PTR) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = READ;
                    end
                end
            end

            DONE: begin
                ptr_d   = FIRST_PTR;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ptr_d   = FIRST_PTR;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == VALID);
        done_d = (state_d == DONE);
    end

    assign ra         = ptr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dout_valid = valid_q;
    assign dout_data  = data_q;
    assign dout_addr  = addr_q;

endmodule

// File: tb/tb_regfile_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump
//
// Purpose:
//   Self-checking bench for regfile_dump. A behavioural register file (x31
//   reads as zero) feeds the read port; the expected stream of a dump is the
//   ordered list of (address, register value) pairs over the configured
//   window. A second instance covers a single-register window.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_regfile_dump;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        dout_ready;
    logic        busy, done, dout_valid;
    logic [4:0]  ra, dout_addr;
    logic [63:0] rd, dout_data;

    logic        start2, ready2;
    logic        busy2, done2, valid2;
    logic [4:0]  ra2, addr2;
    logic [63:0] rd2, data2;

    logic [63:0] rf [NREG];

    int checks = 0;
    int errors = 0;

    logic [4:0]  got_addr [$];
    logic [63:0] got_data [$];
    int          done_cnt, viol_cnt, done_cyc, first_valid_cyc;
    bit          timed_out;

    always #5 clk = ~clk;

    // Behavioural register file: x31 is the zero register.
    assign rd  = (ra  == 5'd31) ? 64'd0 : rf[ra];
    assign rd2 = (ra2 == 5'd31) ? 64'd0 : rf[ra2];

    regfile_dump #(.DATA_W(64), .ADDR_W(5), .FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .ra(ra), .rd(rd), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_addr(dout_addr)
    );

    regfile_dump #(.DATA_W(64), .ADDR_W(5), .FIRST_REG(5), .LAST_REG(5)) dut_single (
        .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .ra(ra2), .rd(rd2), .dout_valid(valid2), .dout_ready(ready2),
        .dout_data(data2), .dout_addr(addr2)
    );

    // Reference value of register a as seen through the read port.
    function automatic logic [63:0] model_word(input int a);
        return (a == 31) ? 64'd0 : rf[a];
    endfunction

    task automatic init_regs_index();
        for (int i = 0; i < NREG; i++) rf[i] = 64'(i);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        start = 1'b0; start2 = 1'b0; dout_ready = 1'b0; ready2 = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one dump on the main instance and records what the consumer saw.
    // Cycle numbers count rising edges from the edge that samples start.
    // Protocol slips (word changing or vanishing while stalled, valid
    // without busy) are tallied in viol_cnt for the caller to judge.
    task automatic collect_dump(input int ready_pct, input int stall_addr,
                                input int stall_len, input bit hold_start,
                                input int max_cycles);
        int          cyc;
        int          stall_left;
        bit          prev_stall, finished;
        logic [63:0] prev_data;
        logic [4:0]  prev_addr;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0; viol_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        timed_out = 1'b0; prev_stall = 1'b0; finished = 1'b0;
        stall_left = stall_len; cyc = 0;
        prev_data = '0; prev_addr = '0;
        @(negedge clk);
        start = 1'b1;
        dout_ready = 1'b0;
        while (!finished && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
            if (prev_stall && !(dout_valid && dout_data == prev_data && dout_addr == prev_addr))
                viol_cnt++;
            if (dout_valid && !busy) viol_cnt++;
            if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc) finished = 1'b1;
            if (dout_valid && int'(dout_addr) == stall_addr && stall_left > 0) begin
                dout_ready = 1'b0;
                stall_left--;
            end else begin
                dout_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (dout_valid && dout_ready) begin
                got_addr.push_back(dout_addr);
                got_data.push_back(dout_data);
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
            prev_addr  = dout_addr;
        end
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 1'b0; start2 = 1'b0; dout_ready = 1'b0; ready2 = 1'b0;
        init_regs_index();
        #1 reset_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", dout_valid); end
        checks++; if (dout_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", dout_data); end
        checks++; if (dout_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", dout_addr); end
        checks++; if (ra !== 5'd0) begin errors++; $display("[TB] FAIL reset_ra: got %0d expected 0", ra); end
        checks++; if (ra2 !== 5'd5) begin errors++; $display("[TB] FAIL reset_ra_single: got %0d expected 5", ra2); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_full_dump();
        init_regs_index();
        collect_dump(100, -1, 0, 1'b0, 300);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL full_timeout: no done within 300 cycles"); end
        checks++; if (got_addr.size() != 32) begin errors++; $display("[TB] FAIL full_count: got %0d words expected 32", got_addr.size()); end
        for (int i = 0; i < got_addr.size() && i < 32; i++) begin
            checks++;
            if (got_addr[i] !== 5'(i) || got_data[i] !== model_word(i)) begin
                errors++;
                $display("[TB] FAIL full_word%0d: got addr %0d data %0h expected addr %0d data %0h",
                         i, got_addr[i], got_data[i], i, model_word(i));
            end
        end
        checks++; if (first_valid_cyc != 2) begin errors++; $display("[TB] FAIL full_first_valid: got cycle %0d expected 2", first_valid_cyc); end
        checks++; if (done_cyc != 65) begin errors++; $display("[TB] FAIL full_done_cycle: got %0d expected 65", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL full_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (viol_cnt != 0) begin errors++; $display("[TB] FAIL full_protocol: got %0d slips expected 0", viol_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_write_before_start();
        init_regs_index();
        rf[0]  = 64'hFF;
        rf[31] = 64'hC0C0;
        collect_dump(100, -1, 0, 1'b0, 300);
        checks++; if (got_addr.size() != 32) begin errors++; $display("[TB] FAIL wr_count: got %0d words expected 32", got_addr.size()); end
        if (got_addr.size() == 32) begin
            checks++; if (got_data[0] !== 64'hFF || got_addr[0] !== 5'd0) begin errors++; $display("[TB] FAIL wr_x0: got addr %0d data %0h expected addr 0 data ff", got_addr[0], got_data[0]); end
            checks++; if (got_data[31] !== 64'd0) begin errors++; $display("[TB] FAIL wr_x31: got %0h expected 0", got_data[31]); end
        end
        for (int i = 0; i < got_addr.size() && i < 32; i++) begin
            checks++;
            if (got_addr[i] !== 5'(i) || got_data[i] !== model_word(i)) begin
                errors++;
                $display("[TB] FAIL wr_word%0d: got addr %0d data %0h expected addr %0d data %0h",
                         i, got_addr[i], got_data[i], i, model_word(i));
            end
        end
    endtask

    task automatic test_backpressure_stall();
        init_regs_index();
        collect_dump(100, 3, 5, 1'b0, 300);
        checks++; if (got_addr.size() != 32) begin errors++; $display("[TB] FAIL stall_count: got %0d words expected 32", got_addr.size()); end
        for (int i = 0; i < got_addr.size() && i < 32; i++) begin
            checks++;
            if (got_addr[i] !== 5'(i) || got_data[i] !== model_word(i)) begin
                errors++;
                $display("[TB] FAIL stall_word%0d: got addr %0d data %0h expected addr %0d data %0h",
                         i, got_addr[i], got_data[i], i, model_word(i));
            end
        end
        checks++; if (viol_cnt != 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d slips expected 0", viol_cnt); end
        checks++; if (done_cyc != 70) begin errors++; $display("[TB] FAIL stall_done_cycle: got %0d expected 70", done_cyc); end
    endtask

    task automatic test_start_held();
        init_regs_index();
        collect_dump(100, -1, 0, 1'b1, 300);
        checks++; if (got_addr.size() != 32) begin errors++; $display("[TB] FAIL held_count: got %0d words expected 32", got_addr.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL held_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != 65) begin errors++; $display("[TB] FAIL held_done_cycle: got %0d expected 65", done_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_idle_busy: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL held_restart_busy: got %b expected 1", busy); end
        start = 1'b0;
        apply_reset();
    endtask

    task automatic test_reset_abort();
        bit found;
        init_regs_index();
        found = 1'b0;
        @(negedge clk);
        start = 1'b1;
        dout_ready = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dout_valid && dout_addr == 5'd10) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL abort_reach_word10: not reached within 100 cycles"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (ra !== 5'd0) begin errors++; $display("[TB] FAIL abort_ra: got %0d expected 0", ra); end
        @(negedge clk);
        reset_n = 1'b1;
        dout_ready = 1'b0;
        collect_dump(100, -1, 0, 1'b0, 300);
        checks++; if (got_addr.size() != 32) begin errors++; $display("[TB] FAIL abort_count: got %0d words expected 32", got_addr.size()); end
        if (got_addr.size() > 0) begin
            checks++; if (got_addr[0] !== 5'd0) begin errors++; $display("[TB] FAIL abort_restart_addr: got %0d expected 0", got_addr[0]); end
        end
        checks++; if (done_cyc != 65) begin errors++; $display("[TB] FAIL abort_done_cycle: got %0d expected 65", done_cyc); end
    endtask

    task automatic test_single_word();
        int          cyc, words, dcyc, dn;
        logic [4:0]  ga;
        logic [63:0] gd;
        init_regs_index();
        cyc = 0; words = 0; dcyc = -1; dn = 0; ga = '0; gd = '0;
        @(negedge clk);
        start2 = 1'b1;
        ready2 = 1'b1;
        while (cyc < 20 && !(dcyc >= 0 && cyc > dcyc)) begin
            @(negedge clk);
            cyc++;
            start2 = 1'b0;
            if (valid2 && ready2) begin words++; ga = addr2; gd = data2; end
            if (done2) begin dn++; if (dcyc < 0) dcyc = cyc; end
        end
        checks++; if (words != 1) begin errors++; $display("[TB] FAIL single_count: got %0d words expected 1", words); end
        checks++; if (ga !== 5'd5 || gd !== model_word(5)) begin errors++; $display("[TB] FAIL single_word: got addr %0d data %0h expected addr 5 data %0h", ga, gd, model_word(5)); end
        checks++; if (dcyc != 3) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d expected 3", dcyc); end
        checks++; if (dn != 1) begin errors++; $display("[TB] FAIL single_done_pulses: got %0d expected 1", dn); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy2); end
        ready2 = 1'b0;
    endtask

    task automatic test_random_backpressure();
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NREG; i++) rf[i] = {$urandom, $urandom};
            collect_dump(30 + 20 * it, -1, 0, 1'b0, 3000);
            checks++; if (timed_out || got_addr.size() != 32) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d words expected 32", it, got_addr.size()); end
            for (int i = 0; i < got_addr.size() && i < 32; i++) begin
                checks++;
                if (got_addr[i] !== 5'(i) || got_data[i] !== model_word(i)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_word%0d: got addr %0d data %0h expected addr %0d data %0h",
                             it, i, got_addr[i], got_data[i], i, model_word(i));
                end
            end
            checks++; if (viol_cnt != 0) begin errors++; $display("[TB] FAIL rand%0d_protocol: got %0d slips expected 0", it, viol_cnt); end
            checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL rand%0d_done_pulses: got %0d expected 1", it, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_write_before_start();
        test_backpressure_stall();
        test_start_held();
        test_reset_abort();
        test_single_word();
        test_random_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
